hack_data_memory: RTL
=====================

Name: hack_data_memory

Overview:
- Data-memory stage directly downstream of the Hack CPU.
- Consumes the CPU's outM, writeM and addressM, and returns inM in the same cycle.
- Maps a 16K-word RAM, an 8K-word screen buffer and a keyboard register fed by a small key FIFO with a valid/ready handshake.
- Provides a second, synchronous read port on the screen buffer for the display scanner.

Parameters:
- KEY_DEPTH, 4, key FIFO depth in entries; must be a power of 2, ≥2.
- KEY_AW, 2, key FIFO pointer width; log2(KEY_DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addressM  input  15  CPU data address.
- outM  input  16  CPU write data.
- writeM  input  1  CPU write strobe.
- inM  output  16  read data to the CPU; combinational from addressM.
- key_data  input  16  key code from the keyboard front-end.
- key_valid  input  1  key_data is valid this cycle.
- key_ready  output  1  FIFO can accept a key this cycle.
- scr_addr  input  13  display scanner read address.
- scr_data  output  16  display read data; registered, 1-cycle latency.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n.
  - During reset: FIFO read/write pointers = 0, count = 0, key_ready = 1 (combinational from count), scr_data = 0.
  - RAM and screen contents are not reset and are undefined until written.
  - Reset asserted mid-operation empties the FIFO immediately; any pending key is lost.
- Address map (addressM):
  - 0x0000–0x3FFF: RAM.
  - 0x4000–0x5FFF: screen, index = addressM[12:0].
  - 0x6000: KBD.
  - 0x6001–0x7FFF: unmapped.
- Reads:
  - inM is combinational, with no clock latency, as required by the single-cycle CPU.
  - RAM and screen return the stored word.
  - KBD returns the FIFO head, or 0x0000 if the FIFO is empty.
  - Unmapped addresses return 0x0000.
- Writes:
  - When writeM = 1 at the rising edge, RAM/screen store outM at that edge. A read of the same address returns the new value from the next cycle on.
  - A write of any value to KBD pops the FIFO head (key acknowledge); this is a no-op if the FIFO is empty.
  - Writes to unmapped addresses are ignored.
- Key FIFO:
  - key_ready = (count < KEY_DEPTH).
  - Push occurs when key_valid && key_ready at the edge.
  - A key_data of 0x0000 is handshaken (accepted) but not stored, because 0 means "no key".
  - Pointers wrap modulo KEY_DEPTH.
- Simultaneous push and pop:
  - Not empty, not full: both occur; count is unchanged.
  - Empty: only the push takes effect; count becomes 1.
  - Full: key_ready = 0, so the push is refused and the pop occurs; count = KEY_DEPTH − 1.
- Display port:
  - scr_data <= screen[scr_addr] on every edge.
  - If the CPU writes the same screen word in the same cycle, scr_data returns the old value (read-before-write).

Optional Feature:
- Macro: HACK_MEM_FAULT_EN.
- When defined, adds output mem_fault (1 bit) and a sticky status register:
  - mem_fault is set at the edge on any write to an unmapped address, or any write to KBD while the FIFO is empty.
  - mem_fault is cleared only by rst_n (reset value 0).
- When not defined, the port is absent and those accesses are silently ignored as described above.

Test Plan:
- RAM write/read: write 0x1234 to 0x0005 with writeM = 1 for one cycle; then with writeM = 0, addressM = 0x0005 → inM = 0x1234 in the same cycle. Then addressM = 0x3FFF (never written) → inM undefined, so the bench writes 0xFFFF there first and checks 0xFFFF.
- Screen dual port:
  - CPU writes 0xAAAA to 0x4010; next cycle scr_addr = 0x0010 → scr_data = 0xAAAA one edge later.
  - Same-edge CPU write of 0x5555 to 0x4010 with scr_addr = 0x0010 → scr_data = 0xAAAA, then 0x5555 on the following edge.
- Keyboard FIFO:
  - Empty → inM@0x6000 = 0x0000.
  - Push 0x0041, 0x0042 → inM@0x6000 = 0x0041.
  - Write to 0x6000 → inM = 0x0042.
  - Write again → 0x0000.
- FIFO full:
  - Push 4 keys (0x31..0x34) → key_ready = 0; a fifth key 0x35 held valid is not accepted.
  - Pop in that cycle → key_ready = 1 next cycle, 0x35 accepted; drain order is 0x32, 0x33, 0x34, 0x35.
- Zero key and simultaneous push/pop on an empty FIFO:
  - Push 0x0000 → count stays 0, inM@0x6000 = 0x0000.
  - Push 0x0020 together with a KBD write while empty → inM = 0x0020 next cycle.
- Unmapped/reset:
  - Write 0xBEEF to 0x7000 → inM@0x7000 = 0x0000, no RAM/screen word changes; with HACK_MEM_FAULT_EN, mem_fault = 1 and stays 1.
  - Assert rst_n low asynchronously with 3 keys queued → key_ready = 1, inM@0x6000 = 0x0000, and mem_fault = 0 immediately.

Source files
------------

// File: rtl/hack_data_memory.sv
// Hack data memory: 16K RAM, 8K-word dual-port screen buffer and a keyboard register fed by a key FIFO.
// Optional sticky fault status output is enabled by defining HACK_MEM_FAULT_EN.
module hack_data_memory #(
    parameter int KEY_DEPTH = 4,
    parameter int KEY_AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic [15:0] key_data,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [12:0] scr_addr,
    output logic [15:0] scr_data
`ifdef HACK_MEM_FAULT_EN
    ,
    output logic        mem_fault
`endif
);

    localparam logic [KEY_AW:0] KeyDepthC = (KEY_AW + 1)'(KEY_DEPTH);

    logic [15:0] ram    [0:16383];
    logic [15:0] screen [0:8191];
    logic [15:0] keyMem [0:KEY_DEPTH-1];

    logic [KEY_AW-1:0] rdPtr;
    logic [KEY_AW-1:0] wrPtr;
    logic [KEY_AW:0]   count;

    logic isRam;
    logic isScr;
    logic isKbd;
    logic keyEmpty;
    logic keyPush;
    logic keyPop;
    logic [15:0] keyHead;

    assign isRam = (addressM[14] == 1'b0);
    assign isScr = (addressM[14:13] == 2'b10);
    assign isKbd = (addressM == 15'h6000);

    // Handshake: a key transfers on any rising edge where key_valid && key_ready;
    // key_ready depends only on FIFO occupancy, never on key_valid.
    assign keyEmpty  = (count == '0);
    assign key_ready = (count < KeyDepthC);
    assign keyPush   = key_valid && key_ready && (key_data != 16'h0000);
    assign keyPop    = writeM && isKbd && !keyEmpty;
    assign keyHead   = keyEmpty ? 16'h0000 : keyMem[rdPtr];

    always_comb begin
        inM = 16'h0000;
        if (isRam) begin
            inM = ram[addressM[13:0]];
        end else if (isScr) begin
            inM = screen[addressM[12:0]];
        end else if (isKbd) begin
            inM = keyHead;
        end
    end

    // Storage arrays carry no reset so they map onto plain memories.
    always_ff @(posedge clk) begin
        if (writeM && isRam) begin
            ram[addressM[13:0]] <= outM;
        end
        if (writeM && isScr) begin
            screen[addressM[12:0]] <= outM;
        end
        if (keyPush) begin
            keyMem[wrPtr] <= key_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            scr_data <= 16'h0000;
        end else begin
            // Non-blocking read of the old word gives read-before-write on a same-edge CPU write.
            scr_data <= screen[scr_addr];
            if (keyPush) begin
                wrPtr <= wrPtr + KEY_AW'(1);
            end
            if (keyPop) begin
                rdPtr <= rdPtr + KEY_AW'(1);
            end
            count <= count + (KEY_AW + 1)'(keyPush) - (KEY_AW + 1)'(keyPop);
        end
    end

`ifdef HACK_MEM_FAULT_EN
    logic faultEvent;
    assign faultEvent = writeM && ((!isRam && !isScr && !isKbd) || (isKbd && keyEmpty));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_fault <= 1'b0;
        end else if (faultEvent) begin
            mem_fault <= 1'b1;
        end
    end
`endif

endmodule
